// File: rtl/hs_ddr_serializer.sv
// Multi-lane DDR serializer: SYNC byte, LSB-first data words, HS-trail, per-lane differential pair.
// Both bits of a cycle are registered on the rising edge; the clock level selects which one drives the pad.
module hs_ddr_serializer #(
    parameter int          LANES        = 2,
    parameter int          WIDTH        = 8,
    parameter logic [7:0]  SYNC_WORD    = 8'hB8,
    parameter int          TRAIL_CYCLES = 4
) (
    input  logic                     TX_DDR_clk,
    input  logic                     TX_rst,
    input  logic                     Enable,
    input  logic [LANES*WIDTH-1:0]   tx_data,
    input  logic                     tx_valid,
    input  logic                     tx_last,
    output logic                     tx_ready,
    output logic                     busy,
    output logic [LANES-1:0]         Dp,
    output logic [LANES-1:0]         Dn
);
    localparam logic [3:0] SYNC_END  = 4'd3;
    localparam logic [3:0] DATA_END  = 4'(WIDTH/2 - 1);
    localparam logic [3:0] TRAIL_END = 4'(TRAIL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, TRAIL} state_t;

    state_t                 r_state, w_state_n;
    logic [3:0]             r_cnt, w_cnt_n;
    logic [LANES-1:0]       r_rise, r_fall, w_rise_n, w_fall_n;
    logic [LANES*WIDTH-1:0] r_word, w_word_n;
    logic                   r_last, w_last_n;
    logic                   w_word_end, w_rdy_base;
    logic                   w_start, w_load, w_trail, w_shift, w_idle;

    assign w_word_end = (r_state == SYNC && r_cnt == SYNC_END) ||
                        (r_state == DATA && r_cnt == DATA_END);
    assign w_rdy_base = (r_state == SYNC && r_cnt == SYNC_END) ||
                        (r_state == DATA && r_cnt == DATA_END && !r_last);
    assign tx_ready   = Enable & w_rdy_base;
    assign busy       = (r_state != IDLE);
    assign Dp         = TX_DDR_clk ? r_rise : r_fall;
    assign Dn         = busy ? ~Dp : '0;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_rise_n  = r_rise;
        w_fall_n  = r_fall;
        w_word_n  = r_word;
        w_last_n  = r_last;
        w_start   = 1'b0;
        w_load    = 1'b0;
        w_trail   = 1'b0;
        w_shift   = 1'b0;
        w_idle    = 1'b0;

        case (r_state)
            IDLE: w_start = tx_valid;
            SYNC, DATA: begin
                // A word boundary either chains the next word or falls into the trail.
                if (w_word_end) begin
                    if (tx_ready && tx_valid) w_load  = 1'b1;
                    else                      w_trail = 1'b1;
                end else begin
                    w_shift = 1'b1;
                end
            end
            TRAIL: begin
                if (r_cnt == TRAIL_END) begin
                    if (tx_valid) w_start = 1'b1;
                    else          w_idle  = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + 4'd1;
                end
            end
            default: w_idle = 1'b1;
        endcase

        if (!Enable) begin
            w_start = 1'b0;
            w_load  = 1'b0;
            w_trail = 1'b0;
            w_shift = 1'b0;
            w_idle  = 1'b1;
        end

        if (w_idle) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
            w_rise_n  = '0;
            w_fall_n  = '0;
            w_word_n  = '0;
            w_last_n  = 1'b0;
        end else if (w_start) begin
            w_state_n = SYNC;
            w_cnt_n   = '0;
            w_last_n  = 1'b0;
            for (int l = 0; l < LANES; l++) begin
                w_rise_n[l]                  = SYNC_WORD[0];
                w_fall_n[l]                  = SYNC_WORD[1];
                w_word_n[l*WIDTH +: WIDTH]   = WIDTH'(SYNC_WORD >> 2);
            end
        end else if (w_load) begin
            w_state_n = DATA;
            w_cnt_n   = '0;
            w_last_n  = tx_last;
            for (int l = 0; l < LANES; l++) begin
                w_rise_n[l]                  = tx_data[l*WIDTH];
                w_fall_n[l]                  = tx_data[l*WIDTH + 1];
                w_word_n[l*WIDTH +: WIDTH]   = tx_data[l*WIDTH +: WIDTH] >> 2;
            end
        end else if (w_trail) begin
            // The fall register still holds the last bit sent on each lane.
            w_state_n = TRAIL;
            w_cnt_n   = '0;
            w_rise_n  = ~r_fall;
            w_fall_n  = ~r_fall;
        end else if (w_shift) begin
            w_cnt_n = r_cnt + 4'd1;
            for (int l = 0; l < LANES; l++) begin
                w_rise_n[l]                  = r_word[l*WIDTH];
                w_fall_n[l]                  = r_word[l*WIDTH + 1];
                w_word_n[l*WIDTH +: WIDTH]   = r_word[l*WIDTH +: WIDTH] >> 2;
            end
        end
    end

    always_ff @(posedge TX_DDR_clk or posedge TX_rst) begin
        if (TX_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_word  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_rise  <= w_rise_n;
            r_fall  <= w_fall_n;
            r_word  <= w_word_n;
            r_last  <= w_last_n;
        end
    end

endmodule

// File: tb/tb_hs_ddr_serializer.sv
// Bench for hs_ddr_serializer: a 2x8 instance and a 1x16 instance share clock, reset and data bus.
module tb_hs_ddr_serializer;
    localparam int TRAIL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic [15:0] tx_data;
    logic        tx_valid, tx_last;
    logic        rdy_a, busy_a, rdy_b, busy_b;
    logic [1:0]  dp_a, dn_a;
    logic [0:0]  dp_b, dn_b;

    int checks = 0;
    int errors = 0;

    logic [15:0] q_words[$];
    logic [1:0]  q_dp[$];
    bit          q_bsy[$];

    typedef struct {
        logic [15:0] data;
        logic [7:0]  l0;
        logic [7:0]  l1;
        logic [1:0]  trail;
    } vec_t;
    vec_t tbl[4];

    always #5 clk = ~clk;

    hs_ddr_serializer #(.LANES(2), .WIDTH(8), .SYNC_WORD(8'hB8), .TRAIL_CYCLES(TRAIL)) u_dut_a (
        .TX_DDR_clk(clk), .TX_rst(rst), .Enable(en_a), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_last(tx_last), .tx_ready(rdy_a), .busy(busy_a), .Dp(dp_a), .Dn(dn_a));

    hs_ddr_serializer #(.LANES(1), .WIDTH(16), .SYNC_WORD(8'hB8), .TRAIL_CYCLES(TRAIL)) u_dut_b (
        .TX_DDR_clk(clk), .TX_rst(rst), .Enable(en_b), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_last(tx_last), .tx_ready(rdy_b), .busy(busy_b), .Dp(dp_b), .Dn(dn_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected half-cycle stream: sync byte, every word LSB first, trail, then two idle cycles.
    function automatic void build_model(input bit sel);
        int          lanes = sel ? 1 : 2;
        int          wid   = sel ? 16 : 8;
        logic [7:0]  s     = 8'hB8;
        logic [1:0]  v;
        logic [1:0]  lastb = 2'b00;
        logic [15:0] w;
        q_dp.delete();
        q_bsy.delete();
        for (int i = 0; i < 8; i++) begin
            v = 2'b00;
            for (int l = 0; l < lanes; l++) v[l] = s[i];
            q_dp.push_back(v); q_bsy.push_back(1'b1);
        end
        foreach (q_words[k]) begin
            w = q_words[k];
            for (int b = 0; b < wid; b++) begin
                v = 2'b00;
                for (int l = 0; l < lanes; l++) v[l] = w[l*wid + b];
                q_dp.push_back(v); q_bsy.push_back(1'b1);
                lastb = v;
            end
        end
        for (int t = 0; t < 2*TRAIL; t++) begin
            v = 2'b00;
            for (int l = 0; l < lanes; l++) v[l] = ~lastb[l];
            q_dp.push_back(v); q_bsy.push_back(1'b1);
        end
        for (int t = 0; t < 4; t++) begin
            q_dp.push_back(2'b00); q_bsy.push_back(1'b0);
        end
    endfunction

    task automatic run_burst(input bit sel, input bit end_last);
        int         n = q_words.size();
        int         h_tot;
        int         acc = 0;
        int         rdys = 0;
        int         idx = 0;
        logic [1:0] mask = sel ? 2'b01 : 2'b11;
        build_model(sel);
        h_tot = q_dp.size();
        en_a = !sel;
        en_b = sel;
        @(posedge clk); #1;
        tx_data  = q_words[0];
        tx_last  = end_last && (n == 1);
        tx_valid = 1'b1;
        fork
            begin
                for (int c = 0; c < h_tot/2 + 1; c++) begin
                    logic r, a;
                    @(negedge clk); #1;
                    r = sel ? rdy_b : rdy_a;
                    a = tx_valid && r;
                    if (a) acc++;
                    if (r) rdys++;
                    @(posedge clk); #1;
                    if (a) begin
                        idx++;
                        if (idx < n) begin
                            tx_data = q_words[idx];
                            tx_last = end_last && (idx == n-1);
                        end else begin
                            tx_valid = 1'b0;
                            tx_last  = 1'b0;
                        end
                    end
                end
            end
            begin
                for (int h = 0; h < h_tot; h++) begin
                    logic [1:0] dp, dn;
                    logic       bz;
                    if (h % 2 == 0) begin @(posedge clk); #2; end
                    else            begin @(negedge clk); #2; end
                    dp = sel ? {1'b0, dp_b} : dp_a;
                    dn = sel ? {1'b0, dn_b} : dn_a;
                    bz = sel ? busy_b : busy_a;
                    chk($sformatf("Dp half %0d", h), dp, q_dp[h]);
                    chk($sformatf("Dn half %0d", h), dn, q_bsy[h] ? (~q_dp[h] & mask) : 2'b00);
                    chk($sformatf("busy half %0d", h), bz, q_bsy[h]);
                end
            end
        join
        chk("accepted words", acc, n);
        chk("ready pulses", rdys, end_last ? n : n + 1);
    endtask

    initial begin
        logic [1:0]  cap[24];
        logic [7:0]  s0, s1, b0, b1;
        logic [15:0] tr;
        logic        got;

        tbl[0] = '{16'hC35A, 8'h5A, 8'hC3, 2'b01};
        tbl[1] = '{16'h0000, 8'h00, 8'h00, 2'b11};
        tbl[2] = '{16'hFFFF, 8'hFF, 8'hFF, 2'b00};
        tbl[3] = '{16'h807F, 8'h7F, 8'h80, 2'b01};

        // Reset state, with inputs trying to start a burst.
        rst = 1'b1; en_a = 1'b1; en_b = 1'b1;
        tx_data = 16'hFFFF; tx_valid = 1'b1; tx_last = 1'b0;
        #12;
        chk("reset busy_a", busy_a, 0);
        chk("reset rdy_a", rdy_a, 0);
        chk("reset Dp_a", dp_a, 0);
        chk("reset Dn_a", dn_a, 0);
        chk("reset busy_b", busy_b, 0);
        chk("reset Dp_b", dp_b, 0);
        tx_valid = 1'b0; en_b = 1'b0;
        @(negedge clk); rst = 1'b0;

        // Single-word bursts reconstructed from both phases.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            tx_data = tbl[k].data; tx_last = 1'b1; tx_valid = 1'b1;
            for (int h = 0; h < 24; h++) begin
                if (h % 2 == 0) begin @(posedge clk); #2; end
                else            begin @(negedge clk); #2; end
                cap[h] = dp_a;
                if (h == 8) begin tx_valid = 1'b0; tx_last = 1'b0; end
            end
            for (int b = 0; b < 8; b++) begin
                s0[b] = cap[b][0];   s1[b] = cap[b][1];
                b0[b] = cap[8+b][0]; b1[b] = cap[8+b][1];
                tr[2*b] = cap[16+b][0]; tr[2*b+1] = cap[16+b][1];
            end
            chk($sformatf("vec%0d sync lane0", k), s0, 8'hB8);
            chk($sformatf("vec%0d sync lane1", k), s1, 8'hB8);
            chk($sformatf("vec%0d data lane0", k), b0, tbl[k].l0);
            chk($sformatf("vec%0d data lane1", k), b1, tbl[k].l1);
            chk($sformatf("vec%0d trail", k), tr, {8{tbl[k].trail}});
            @(posedge clk); #2;
            chk($sformatf("vec%0d busy after trail", k), busy_a, 0);
            chk($sformatf("vec%0d Dp after trail", k), dp_a, 0);
        end

        // Asynchronous reset in the middle of a word.
        @(posedge clk); #1;
        tx_data = 16'hFFFF; tx_valid = 1'b1; tx_last = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("mid-data busy", busy_a, 1);
        chk("mid-data Dp", dp_a, 2'b11);
        rst = 1'b1; #1;
        chk("async rst Dp", dp_a, 0);
        chk("async rst Dn", dn_a, 0);
        chk("async rst busy", busy_a, 0);
        chk("async rst ready", rdy_a, 0);
        tx_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #2;
        chk("idle after rst", busy_a, 0);

        // Enable dropped during DATA cycle 2: abort without trail, pending word refused.
        @(posedge clk); #1;
        tx_data = 16'hA55A; tx_valid = 1'b1; tx_last = 1'b0;
        repeat (5) @(posedge clk);
        repeat (2) @(posedge clk);
        #1; en_a = 1'b0; #1;
        chk("abort pre-edge busy", busy_a, 1);
        chk("abort pre-edge ready", rdy_a, 0);
        @(posedge clk); #2;
        chk("abort busy", busy_a, 0);
        chk("abort Dp high", dp_a, 0);
        chk("abort Dn high", dn_a, 0);
        @(negedge clk); #2;
        chk("abort Dp low", dp_a, 0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #2;
            chk("disabled busy", busy_a, 0);
            chk("disabled ready", rdy_a, 0);
        end
        tx_valid = 1'b0; en_a = 1'b1;
        @(posedge clk); #2;
        chk("re-enable idle", busy_a, 0);

        // Back-to-back bursts: next burst starts at the edge ending the trail.
        @(posedge clk); #1;
        tx_data = 16'h1234; tx_valid = 1'b1; tx_last = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk); #1;
            if (rdy_a) got = 1'b1;
        end
        chk("b2b first accept", got, 1);
        @(posedge clk); #1;
        tx_data = 16'h00FF; tx_last = 1'b1; tx_valid = 1'b1;
        repeat (7) @(posedge clk);
        #2;
        chk("b2b trail busy", busy_a, 1);
        chk("b2b trail Dp", dp_a, 2'b11);
        @(posedge clk); #2;
        chk("b2b restart busy", busy_a, 1);
        chk("b2b sync bit0 Dp", dp_a, 2'b00);
        chk("b2b sync bit0 Dn", dn_a, 2'b11);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk); #2;
        chk("b2b sync bit3 Dp", dp_a, 2'b11);
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk); #1;
            if (rdy_a) got = 1'b1;
        end
        chk("b2b second accept", got, 1);
        @(posedge clk); #1;
        tx_valid = 1'b0; tx_last = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #2;
            if (!busy_a) got = 1'b1;
        end
        chk("b2b returns idle", got, 1);

        // Randomised bursts against the reference stream, last-tagged or underrun.
        for (int k = 0; k < 6; k++) begin
            int n = $urandom_range(1, 4);
            q_words.delete();
            for (int i = 0; i < n; i++) q_words.push_back(16'($urandom()));
            run_burst(1'b0, 1'($urandom_range(0, 1)));
        end

        // Wide single-lane instance: five random words, last on the fifth.
        q_words.delete();
        for (int i = 0; i < 5; i++) q_words.push_back(16'($urandom()));
        run_burst(1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            int n = $urandom_range(1, 3);
            q_words.delete();
            for (int i = 0; i < n; i++) q_words.push_back(16'($urandom()));
            run_burst(1'b1, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hs_ddr_serializer.md
HS_DDR_SERIALIZER -- requirements
Module: hs_ddr_serializer

Interface
REQ-001 SHALL have parameter LANES, 2, number of data lanes (legal 1..4).
REQ-002 SHALL have parameter WIDTH, 8, bits per lane word (even, legal 8..16).
REQ-003 SHALL have parameter SYNC_WORD, 8'hB8, HS sync byte sent LSB first on every lane.
REQ-004 SHALL have parameter TRAIL_CYCLES, 4, HS-trail length in clock cycles (legal 1..15).
REQ-005 SHALL have port TX_DDR_clk  input  1  sole clock; both edges drive data.
REQ-006 SHALL have port TX_rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port Enable  input  1  burst permission; low aborts immediately.
REQ-008 SHALL have port tx_data  input  LANES*WIDTH  lane l word at [l*WIDTH +: WIDTH].
REQ-009 SHALL have port tx_valid  input  1  tx_data/tx_last are valid.
REQ-010 SHALL have port tx_last  input  1  marks final word of burst.
REQ-011 SHALL have port tx_ready  output  1  word accepted on rising edge when tx_valid & tx_ready.
REQ-012 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-013 SHALL have port Dp  output  LANES  positive differential data per lane.
REQ-014 SHALL have port Dn  output  LANES  negative differential data per lane.

Function
REQ-015 SHALL implement states IDLE, SYNC, DATA, TRAIL; all transitions on rising edge of TX_DDR_clk.
REQ-016 SHALL, per cycle, drive bit 2k from rising edge to falling edge and bit 2k+1 from falling edge to next rising edge (rise register + fall register + clock-level output mux).
REQ-017 SHALL serialise LSB first; one WIDTH word per lane occupies WIDTH/2 cycles; SYNC occupies 4 cycles.
REQ-018 SHALL, in SYNC/DATA/TRAIL, drive Dn = ~Dp per lane; in IDLE drive Dp = Dn = 0.
REQ-019 SHALL move IDLE->SYNC at rising edge E0 with Enable=1 and tx_valid=1; SYNC_WORD bit0 appears on Dp in the high phase following E0 (zero-cycle latency from decision edge).
REQ-020 SHALL assert tx_ready only when Enable=1 and either (SYNC, cycle 3) or (DATA, last cycle of word, current word not tagged last); tx_ready=0 in IDLE and TRAIL.
REQ-021 SHALL, on accept, load the word so that its bit0 appears in the high phase following the accepting edge (no gap between words).
REQ-022 SHALL enter TRAIL at a word boundary when the current word was tagged last or tx_valid=0 while tx_ready=1 (underrun).
REQ-023 SHALL in TRAIL drive each lane to the inverse of its last transmitted bit in both half-cycles for exactly TRAIL_CYCLES cycles, then enter IDLE.
REQ-024 SHALL, when Enable=0 at any rising edge, enter IDLE at that edge, accept nothing, and drive Dp=Dn=0 from that edge (no trail).
REQ-025 SHALL drive all lanes in lockstep; tx_data of all lanes is captured by one handshake.
REQ-026 SHALL allow IDLE->SYNC at the edge ending TRAIL if Enable & tx_valid (back-to-back bursts).
REQ-027 SHALL keep tx_ready and busy glitch-free (decoded from registered state only, except Enable gating of tx_ready).

Reset
REQ-028 SHALL on TX_rst=1 immediately clear state to IDLE, counters to 0, rise/fall registers to 0, Dp=Dn=0, tx_ready=0, busy=0.
REQ-029 SHALL, on reset mid-burst, discard held data; first burst after release starts with SYNC.
REQ-030 SHALL leave tx_ready=0 until SYNC cycle 3 of the first burst after release.

Verification
REQ-031 Reset asserted mid-DATA -> Dp=Dn=0, busy=0, tx_ready=0 within same clock phase, no clock needed.
REQ-032 LANES=2, WIDTH=8, one word {8'h5A,8'hC3} tx_last=1 -> lane0 Dp half-cycle sequence 0,0,0,1,1,1,0,1 (B8) then 0,1,0,1,1,0,1,0 then 1 for 8 halves (trail), busy low after; lane1 data 1,1,0,0,0,0,1,1 then trail 0.
REQ-033 Three words streamed with tx_valid held high -> tx_ready pulses once per word, 24 data bits contiguous, no idle half-cycle between words.
REQ-034 tx_valid dropped at word boundary without tx_last -> TRAIL entered, TRAIL_CYCLES=4 cycles of inverted last bit, then IDLE.
REQ-035 Enable cleared in DATA cycle 2 -> IDLE at that edge, Dp=Dn=0, no trail, pending word not accepted.
REQ-036 WIDTH=16, LANES=1, random words, tx_last on 5th -> scoreboard reconstruction from both edges matches input exactly.
